// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for the unified memory port.
// Latches one-cycle request pulses from the icache (0) and dcache (1), drives a level
// valid/ready handshake to memory and returns a one-cycle response pulse to the owner.
// A watchdog aborts a stuck transaction. Overflow and timeout flags stay set until reset.
module mem_port_arbiter #(
  parameter int unsigned AW      = 16,
  parameter int unsigned LW      = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  input  logic [1:0]      req_rw,
  input  logic [2*AW-1:0] req_addr,
  input  logic [2*LW-1:0] req_wdata,
  output logic [1:0]      resp_ready,
  output logic [LW-1:0]   resp_rdata,
  output logic            mem_valid,
  output logic            mem_rw,
  output logic [AW-1:0]   mem_addr,
  output logic [LW-1:0]   mem_wdata,
  input  logic            mem_ready,
  input  logic [LW-1:0]   mem_rdata,
  output logic            overflow_err,
  output logic            timeout_err
);

  localparam int unsigned WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e                 state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   rr_last_q, rr_last_d;
  logic [WDW-1:0]         wd_q, wd_d;

  logic [1:0]             pend_q, pend_d;
  logic [1:0]             slot_rw_q, slot_rw_d;
  logic [1:0][AW-1:0]     slot_addr_q, slot_addr_d;
  logic [1:0][LW-1:0]     slot_wdata_q, slot_wdata_d;

  logic                   mem_valid_q, mem_valid_d;
  logic                   mem_rw_q, mem_rw_d;
  logic [AW-1:0]          mem_addr_q, mem_addr_d;
  logic [LW-1:0]          mem_wdata_q, mem_wdata_d;
  logic [1:0]             resp_ready_q, resp_ready_d;
  logic [LW-1:0]          resp_rdata_q, resp_rdata_d;
  logic                   overflow_q, overflow_d;
  logic                   timeout_q, timeout_d;

  logic                   wd_expire;
  logic                   done;
  logic [1:0]             clr;
  logic                   sel;

  // Watchdog fires on the TIMEOUT-th BUSY cycle without mem_ready; mem_ready has priority.
  assign wd_expire = (TIMEOUT != 0) && (wd_q == WDW'(TIMEOUT - 1));
  assign done      = (state_q == StBusy) && (mem_ready || wd_expire);
  assign clr       = done ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

  // Request slot capture: a new pulse wins over the clear of the ending transaction.
  always_comb begin
    pend_d       = pend_q;
    slot_rw_d    = slot_rw_q;
    slot_addr_d  = slot_addr_q;
    slot_wdata_d = slot_wdata_q;
    overflow_d   = overflow_q;
    for (int i = 0; i < 2; i++) begin
      if (clr[i]) begin
        pend_d[i] = 1'b0;
      end
      if (req_valid[i]) begin
        if (pend_q[i] && !clr[i]) begin
          overflow_d = 1'b1;
        end else begin
          pend_d[i]       = 1'b1;
          slot_rw_d[i]    = req_rw[i];
          slot_addr_d[i]  = req_addr[i*AW +: AW];
          slot_wdata_d[i] = req_wdata[i*LW +: LW];
        end
      end
    end
  end

  // Grant / transfer FSM; responses are registered one-cycle pulses.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_last_d    = rr_last_q;
    wd_d         = wd_q;
    mem_valid_d  = mem_valid_q;
    mem_rw_d     = mem_rw_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_ready_d = 2'b00;
    resp_rdata_d = '0;
    timeout_d    = timeout_q;
    sel          = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|pend_q) begin
          // On a tie the requester that was not served last goes first.
          sel         = (&pend_q) ? ~rr_last_q : pend_q[1];
          owner_d     = sel;
          rr_last_d   = sel;
          wd_d        = '0;
          mem_valid_d = 1'b1;
          mem_rw_d    = slot_rw_q[sel];
          mem_addr_d  = slot_addr_q[sel];
          mem_wdata_d = slot_wdata_q[sel];
          state_d     = StBusy;
        end
      end
      StBusy: begin
        if (mem_ready) begin
          mem_valid_d           = 1'b0;
          resp_ready_d[owner_q] = 1'b1;
          resp_rdata_d          = mem_rw_q ? '0 : mem_rdata;
          state_d               = StIdle;
        end else if (wd_expire) begin
          mem_valid_d           = 1'b0;
          resp_ready_d[owner_q] = 1'b1;
          timeout_d             = 1'b1;
          state_d               = StIdle;
        end else if (TIMEOUT != 0) begin
          wd_d = wd_q + WDW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      rr_last_q    <= 1'b1;
      wd_q         <= '0;
      pend_q       <= 2'b00;
      slot_rw_q    <= 2'b00;
      slot_addr_q  <= '0;
      slot_wdata_q <= '0;
      mem_valid_q  <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_ready_q <= 2'b00;
      resp_rdata_q <= '0;
      overflow_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_last_q    <= rr_last_d;
      wd_q         <= wd_d;
      pend_q       <= pend_d;
      slot_rw_q    <= slot_rw_d;
      slot_addr_q  <= slot_addr_d;
      slot_wdata_q <= slot_wdata_d;
      mem_valid_q  <= mem_valid_d;
      mem_rw_q     <= mem_rw_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_ready_q <= resp_ready_d;
      resp_rdata_q <= resp_rdata_d;
      overflow_q   <= overflow_d;
      timeout_q    <= timeout_d;
    end
  end

  assign resp_ready   = resp_ready_q;
  assign resp_rdata   = resp_rdata_q;
  assign mem_valid    = mem_valid_q;
  assign mem_rw       = mem_rw_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign overflow_err = overflow_q;
  assign timeout_err  = timeout_q;

endmodule
